fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage plus IF/ID pipeline register for the pipelined RISC-V core. It holds the PC, issues requests to the instruction memory (up to two outstanding), and buffers responses in a 2-entry prefetch queue. It presents one instruction per cycle to decode. It consumes StallF/StallD from the hazard unit and the redirect (PCSrcE, PCTargetE, FlushD) from execute.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- NOP, 32'h0000_0013, instruction word driven on InstrD for a bubble (addi x0,x0,0)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- StallF  in  1  hazard unit: no new imem request this cycle
- StallD  in  1  hazard unit: hold IF/ID register contents
- FlushD  in  1  execute: IF/ID register becomes a bubble
- PCSrcE  in  1  execute: redirect fetch to PCTargetE
- PCTargetE  in  32  redirect target
- imem_req  out  1  request valid
- imem_addr  out  32  request address (word aligned)
- imem_ready  in  1  memory accepts request when imem_req & imem_ready
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after acceptance
- imem_rdata  in  32  response instruction
- InstrD  out  32  instruction in decode
- PCD  out  32  PC of InstrD
- PCPlus4D  out  32  PCD + 4
- ValidD  out  1  InstrD is a real instruction
- MisalignD  out  1  only with FETCH_MISALIGN_EN, see Configuration

## Operation
- PCF register: next request address. It advances by 4 on each accepted request and is loaded with PCTargetE on a redirect.
- Outstanding counter (0..2) and request-PC FIFO (depth 2) tag each accepted request with its address.
- Prefetch queue: 2 entries of {pc, instr}. occupancy = outstanding + queue count, never above 2.
- imem_req = !reset & !StallF & !PCSrcE & occupancy < 2. This is the only combinational path from PCSrcE.
- Response handling:
  - A response whose drop counter is 0 pops the request-PC FIFO and pushes {pc, rdata} into the queue.
  - A response whose drop counter is nonzero is discarded and the drop counter decrements.
- IF/ID load, when !StallD:
  - Load from the queue head if the queue is nonempty.
  - Otherwise load from the same-cycle live response (bypass) if one is valid.
  - Otherwise load a bubble: ValidD=0, InstrD=NOP, PCD and PCPlus4D unchanged.
- StallD: IF/ID holds. The queue still absorbs responses; issue is limited by occupancy.
- Redirect (PCSrcE=1, FlushD=1 from execute in the same cycle):
  - PCF <= PCTargetE; queue cleared; request-PC FIFO cleared.
  - Drop counter <= outstanding minus any response retiring this cycle.
  - Outstanding is then tracked as drop-only.
  - IF/ID <= bubble.
- FlushD without PCSrcE: IF/ID <= bubble only.
- Priority: reset > PCSrcE > FlushD > StallD > normal load. FlushD overrides StallD.
- A response arriving in the same cycle as PCSrcE is discarded.
- A request accepted in the same cycle as PCSrcE cannot occur (imem_req is gated).

## Timing
- Reset values: PCF=RESET_PC, imem_req=0 during reset, queue empty, outstanding=0, drop=0, InstrD=NOP, PCD=RESET_PC, PCPlus4D=RESET_PC+4, ValidD=0, MisalignD=0.
- 1-cycle memory, no stalls:
  - Request accepted at cycle 0, rvalid in cycle 1, ValidD=1 in cycle 2 (bypass path).
  - Steady state gives one instruction per cycle.
- Redirect asserted in cycle n: first request to the target in cycle n+1; with a 1-cycle memory, that instruction reaches ValidD in cycle n+3.
- Reset asserted mid-operation clears all state immediately. In-flight responses after reset deassertion are not counted. Reset must be held until memory is idle.

## Configuration
- FETCH_MISALIGN_EN defined:
  - A redirect with PCTargetE[1:0]!=0 loads PCF but issues no requests.
  - Once the drop counter reaches 0, IF/ID loads once with ValidD=1, MisalignD=1, InstrD=NOP, PCD=PCTargetE.
  - Fetch then halts until the next redirect.
- FETCH_MISALIGN_EN undefined: the MisalignD port is absent and PCTargetE[1:0] is forced to 2'b00.

## Test plan
- Reset release, 1-cycle memory returning rdata=addr^32'hA5A5_0000 -> ValidD first high at cycle 2 with PCD=0, then PCD=4,8,12… consecutively.
- StallF=StallD=1 for 3 cycles mid-stream -> IF/ID frozen, no more than 2 requests outstanding+queued, and no instruction lost or duplicated after release.
- PCSrcE=1, PCTargetE=0x100 with 2 requests outstanding -> both stale responses dropped, next ValidD has PCD=0x100, InstrD from addr 0x100.
- imem_ready low for 5 cycles, then 3-cycle response latency -> in-order delivery, ValidD=0 gaps, PCPlus4D=PCD+4 always.
- Reset asserted while queue holds 2 entries -> next cycle ValidD=0, InstrD=0x00000013, imem_addr=RESET_PC after release.
- (FETCH_MISALIGN_EN) PCTargetE=0x102 -> no imem_req, then one cycle ValidD=1, MisalignD=1, PCD=0x102; fetch idle until next redirect.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction fetch with the IF/ID pipeline register.
// It keeps up to two imem requests in flight and buffers returns in a 2-entry
// prefetch queue. It presents at most one instruction per cycle to decode.
//
// Ports
//   clk, reset            core clock, async active-high reset
//   StallF, StallD        hazard unit: stop issue / hold IF/ID
//   FlushD                IF/ID becomes a bubble
//   PCSrcE, PCTargetE     redirect from execute
//   imem_req/addr/ready   request channel (accepted on req & ready)
//   imem_rvalid/rdata     in-order response channel
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register
//   MisalignD             only with FETCH_MISALIGN_EN
//
// Optional feature macro: FETCH_MISALIGN_EN. When it is defined, a redirect to
// a non-word-aligned target parks fetch. It then reports a single MisalignD
// marker. When it is undefined, the low target bits are ignored.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        MisalignD
`endif
);

  logic [31:0]      pcf;
  logic [1:0]       outst, drop;          // in-flight requests / how many of them to discard
  logic [1:0][31:0] rq_pc;                // PCs of live (non-dropped) requests, [0] oldest
  logic [1:0]       rq_cnt;
  logic [1:0][31:0] q_pc, q_ins;          // prefetch queue, [0] is head
  logic [1:0]       q_cnt;

  logic [1:0][31:0] rq_pc_n, q_pc_n, q_ins_n;
  logic [1:0]       rq_cnt_n, q_cnt_n, outst_n;
  logic [2:0]       occ;
  logic [31:0]      target;
  logic             fetch_en, accept, rsp, rsp_keep, load_ok, pop, bypass, push, mis_fire;

`ifdef FETCH_MISALIGN_EN
  assign target = PCTargetE;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^PCTargetE[1:0];
  assign target = {PCTargetE[31:2], 2'b00};
`endif

  // Occupancy counts in-flight requests, including those that will be dropped.
  // The queue therefore can never overflow.
  assign occ       = {1'b0, outst} + {1'b0, q_cnt};
  assign imem_req  = !reset && !StallF && !PCSrcE && (occ < 3'd2) && fetch_en;
  assign imem_addr = pcf;
  assign accept    = imem_req && imem_ready;
  // Ignore stray rvalid when nothing is in flight.
  assign rsp       = imem_rvalid && (outst != 2'd0);
  assign rsp_keep  = rsp && (drop == 2'd0) && !PCSrcE;
  assign load_ok   = !StallD && !FlushD && !PCSrcE;
  assign pop       = load_ok && (q_cnt != 2'd0);
  assign bypass    = load_ok && (q_cnt == 2'd0) && rsp_keep;
  assign push      = rsp_keep && !bypass;

  always_comb begin
    q_pc_n  = q_pc;
    q_ins_n = q_ins;
    q_cnt_n = q_cnt;
    if (pop) begin
      q_pc_n[0]  = q_pc[1];
      q_ins_n[0] = q_ins[1];
      q_cnt_n    = q_cnt - 2'd1;
    end
    // After a pop, at most one entry remains when pushing, so bit 0 is enough.
    if (push) begin
      q_pc_n[q_cnt_n[0]]  = rq_pc[0];
      q_ins_n[q_cnt_n[0]] = imem_rdata;
      q_cnt_n             = q_cnt_n + 2'd1;
    end
  end

  always_comb begin
    rq_pc_n  = rq_pc;
    rq_cnt_n = rq_cnt;
    if (rsp_keep) begin
      rq_pc_n[0] = rq_pc[1];
      rq_cnt_n   = rq_cnt - 2'd1;
    end
    if (accept) begin
      rq_pc_n[rq_cnt_n[0]] = pcf;
      rq_cnt_n             = rq_cnt_n + 2'd1;
    end
  end

  assign outst_n = outst + {1'b0, accept} - {1'b0, rsp};

  // PC, request tracking, prefetch queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcf    <= RESET_PC;
      outst  <= 2'd0;
      drop   <= 2'd0;
      rq_pc  <= '0;
      rq_cnt <= 2'd0;
      q_pc   <= '0;
      q_ins  <= '0;
      q_cnt  <= 2'd0;
    end else if (PCSrcE) begin
      // Everything still in flight becomes stale. A response in this cycle
      // retires one of them.
      pcf    <= target;
      rq_cnt <= 2'd0;
      q_cnt  <= 2'd0;
      outst  <= outst - {1'b0, rsp};
      drop   <= outst - {1'b0, rsp};
    end else begin
      if (accept) pcf <= pcf + 32'd4;
      outst  <= outst_n;
      rq_pc  <= rq_pc_n;
      rq_cnt <= rq_cnt_n;
      q_pc   <= q_pc_n;
      q_ins  <= q_ins_n;
      q_cnt  <= q_cnt_n;
      if (rsp && (drop != 2'd0)) drop <= drop - 2'd1;
    end
  end

  // IF/ID register. A bubble keeps PCD/PCPlus4D unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= NOP;
      PCD      <= RESET_PC;
      PCPlus4D <= RESET_PC + 32'd4;
      ValidD   <= 1'b0;
    end else if (PCSrcE || FlushD) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (q_cnt != 2'd0) begin
        InstrD   <= q_ins[0];
        PCD      <= q_pc[0];
        PCPlus4D <= q_pc[0] + 32'd4;
        ValidD   <= 1'b1;
      end else if (rsp_keep) begin
        InstrD   <= imem_rdata;
        PCD      <= rq_pc[0];
        PCPlus4D <= rq_pc[0] + 32'd4;
        ValidD   <= 1'b1;
      end else if (mis_fire) begin
        InstrD   <= NOP;
        PCD      <= pcf;
        PCPlus4D <= pcf + 32'd4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP;
        ValidD <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_EN
  // halt parks issue after a misaligned redirect. mis_pend emits one marker
  // after the stale responses have drained.
  logic halt, mis_pend;
  assign fetch_en = !halt;
  assign mis_fire = mis_pend && (drop == 2'd0) && (q_cnt == 2'd0) && !rsp_keep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt      <= 1'b0;
      mis_pend  <= 1'b0;
      MisalignD <= 1'b0;
    end else if (PCSrcE) begin
      halt      <= |PCTargetE[1:0];
      mis_pend  <= |PCTargetE[1:0];
      MisalignD <= 1'b0;
    end else if (FlushD) begin
      MisalignD <= 1'b0;
    end else if (!StallD) begin
      MisalignD <= mis_fire;
      if (mis_fire) mis_pend <= 1'b0;
    end
  end
`else
  assign fetch_en = 1'b1;
  assign mis_fire = 1'b0;
`endif

endmodule
